// File: rtl/mux_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl_if
//   Manual-override handshake between a host and mux_scan_ctrl.
//
//   manual_req  host -> ctrl  level request, held for the whole manual session
//   manual_sel  host -> ctrl  channel to force while the request is held
//   manual_ack  ctrl -> host  registered acknowledge, high while manual is active
//
//   master : host side
//   slave  : controller side
// -----------------------------------------------------------------------------
interface mux_scan_ctrl_if;
    logic       manual_req;
    logic [3:0] manual_sel;
    logic       manual_ack;

    modport master (
        output manual_req,
        output manual_sel,
        input  manual_ack
    );

    modport slave (
        input  manual_req,
        input  manual_sel,
        output manual_ack
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//   Generates the 4-bit select of a 16:1 datapath mux. In automatic mode it
//   rotates round-robin through the channels enabled in `mask`, holding each
//   for `dwell` cycles (0 behaves as 1). A host can force a channel through the
//   manual req/ack handshake. `advance` pulses for one cycle at the start of
//   every dwell window / new channel so downstream logic can sample the mux.
//
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   enable   in   1 = automatic scanning allowed
//   mask     in   channel participation mask, bit i = channel i
//   dwell    in   cycles per channel (0 treated as 1)
//   host     if   manual_req / manual_sel in, manual_ack out (slave modport)
//   select   out  registered mux select
//   advance  out  registered one-cycle window-start pulse
//   idle     out  registered, high while in IDLE
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [15:0]            mask,
    input  logic [DWELL_WIDTH-1:0] dwell,
    mux_scan_ctrl_if.slave         host,
    output logic [3:0]             select,
    output logic                   advance,
    output logic                   idle
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_MANUAL = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [3:0]             select_next;
    logic                   advance_next;
    logic                   ack_next;
    logic [DWELL_WIDTH-1:0] count, count_next;
    logic [DWELL_WIDTH-1:0] dwell_last;
    logic                   can_scan;

    // First enabled channel at or after x (incl=1) or strictly after x
    // (incl=0), wrapping 15 -> 0. Only called when m != 0.
    function automatic logic [3:0] next_from(input logic [3:0]  x,
                                             input logic        incl,
                                             input logic [15:0] m);
        logic [3:0] start;
        logic [3:0] c;
        logic       found;
        start     = incl ? x : x + 4'd1;
        next_from = start;
        found     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            c = start + 4'(i);
            if (!found && m[c]) begin
                next_from = c;
                found     = 1'b1;
            end
        end
    endfunction

    // Last count value of a window; dwell=0 behaves as dwell=1. Compared
    // live, so a dwell change applies to the current window. If the counter
    // is already past the new limit it simply runs on and wraps.
    assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
    assign can_scan   = enable && (mask != 16'h0000);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        select_next  = select;
        advance_next = 1'b0;
        ack_next     = 1'b0;
        count_next   = '0;

        if (host.manual_req) begin
            // Manual request wins over everything. On entry advance always
            // pulses; while held it pulses only when the channel changes.
            state_next   = ST_MANUAL;
            select_next  = host.manual_sel;
            ack_next     = 1'b1;
            advance_next = (state != ST_MANUAL) || (host.manual_sel != select);
        end else begin
            unique case (state)
                ST_IDLE, ST_MANUAL: begin
                    // Leaving manual and starting from idle behave the same:
                    // resume on the current channel if it is still enabled.
                    if (can_scan) begin
                        state_next   = ST_SCAN;
                        select_next  = next_from(select, 1'b1, mask);
                        advance_next = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (!can_scan) begin
                        state_next = ST_IDLE;
                    end else if (count == dwell_last) begin
                        select_next  = next_from(select, 1'b0, mask);
                        advance_next = 1'b1;
                    end else begin
                        count_next = count + DWELL_WIDTH'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            select          <= 4'd0;
            advance         <= 1'b0;
            host.manual_ack <= 1'b0;
            count           <= '0;
            idle            <= 1'b1;
        end else begin
            state           <= state_next;
            select          <= select_next;
            advance         <= advance_next;
            host.manual_ack <= ack_next;
            count           <= count_next;
            idle            <= (state_next == ST_IDLE);
        end
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Select generator that drives the 4-bit select of the 16:1 datapath mux, directly upstream of it.
- Automatic mode: rotates round-robin through a masked subset of the 16 channels, holding each for a programmable dwell time.
- Manual mode: a host forces a channel through a req/ack handshake.
- Emits a one-cycle strobe at the start of every dwell window so downstream logic can sample the mux output.

Parameters:
- DWELL_WIDTH, 16, width of dwell count input and internal dwell counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = automatic scanning allowed.
- mask  input  16  channel enable; bit i = 1 means channel i takes part in the scan.
- dwell  input  DWELL_WIDTH  cycles spent on each channel; 0 treated as 1.
- manual_req  input  1  host request for manual channel; level, held for the session.
- manual_sel  input  4  channel forced while in manual mode.
- manual_ack  output  1  registered acknowledge; high while manual mode is active.
- select  output  4  registered channel index to the mux select.
- advance  output  1  one-cycle pulse; high in the first cycle of each new dwell window or channel.
- idle  output  1  high when state is IDLE.

Behaviour:
- Reset (async, any time, mid-dwell included): select=0, advance=0, manual_ack=0, idle=1, dwell counter=0, state=IDLE. The first edge after release evaluates from IDLE.
- States: IDLE, SCAN, MANUAL. Priority per cycle: manual_req > scan > idle.
- next_from(x, incl): first channel c with mask[c]=1, searched from x (incl=1) or x+1 (incl=0) upward, wrapping 15->0; always combinational, searches all 16.
- IDLE:
  - manual_req=1 -> MANUAL.
  - else enable=1 and mask!=0 -> SCAN: select<=next_from(select,1), counter<=0, advance<=1.
  - else stay; select holds.
- SCAN:
  - Counter increments each cycle. When counter == max(dwell,1)-1: counter<=0, select<=next_from(select,0), advance<=1.
  - Single enabled channel: select unchanged but advance still pulses every window.
  - Dwell=1: advance high every cycle and select changes every cycle.
  - Dwell changes take effect on the compare immediately. If the counter already exceeds the new limit, the counter wraps at 2^DWELL_WIDTH (no early abort).
  - Mask changes are used at the next channel step. The current channel finishes its window even if now masked.
  - enable=0 or mask==0 -> IDLE next edge: counter<=0, select holds, no advance.
  - manual_req=1 -> MANUAL (overrides dwell expiry in the same cycle).
- MANUAL:
  - Entry edge: select<=manual_sel, manual_ack<=1, advance<=1, counter<=0. Ack appears one cycle after req is sampled.
  - While manual_req=1: select<=manual_sel each edge. Advance pulses only on edges where the new select differs from the old. Mask and enable are ignored.
  - manual_req=0 -> manual_ack<=0 on that edge. If enable=1 and mask!=0 -> SCAN with select<=next_from(select,1), counter<=0, advance<=1; else -> IDLE with select held.
- idle = (state==IDLE), registered with the state.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset then enable=1, mask=16'h0005, dwell=3 -> select 0,0,0,2,2,2,0,...; advance high in the first cycle of each window; idle=0 from the first edge.
- mask=16'h8001, dwell=1 -> select alternates 15,0,15,0 every cycle (wrap); advance constantly 1.
- Scanning with mask=16'h0010, dwell=0 -> select stays 4 and advance pulses every cycle. Then mask->0: IDLE next edge, idle=1, select holds 4.
- During SCAN at select=2, raise manual_req with manual_sel=9 -> next edge select=9, manual_ack=1, advance=1. Change manual_sel to 11 -> select=11 with one advance pulse. Drop req with mask=16'h0F00 -> manual_ack=0, select=11 (inclusive search), scan resumes.
- Assert reset_n=0 asynchronously mid-dwell in MANUAL -> select=0, manual_ack=0, advance=0, idle=1 immediately, without waiting for a clock. After release with enable=0 -> remains IDLE.
- enable=1, mask=16'hFFFF, dwell=2, drop enable mid-window -> IDLE next edge, no advance. Re-enable -> resumes on the same select (inclusive) with an advance pulse.
